nios_pio_pulse: RTL and testbench
=================================

NIOS_PIO_PULSE -- requirements
Module: nios_pio_pulse

Interface
REQ-001 SHALL have parameter WIDTH, default 1, output port width in bits (legal 1..32).
REQ-002 SHALL have parameter RESET_VALUE, default all ones, reset value of DATA (idle-high strobe lines such as LDAC_n).
REQ-003 SHALL have parameter CNT_W, default 16, pulse-length counter width (legal 1..31).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port address, input, 3, Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, read data, combinational from address, zero wait states.
REQ-011 SHALL have port out_port, output, WIDTH, driven output lines.
REQ-012 SHALL have port irq, output, 1, pulse-done interrupt.

Function
REQ-013 SHALL define a write as chipselect=1 and write_n=0 at a rising clk edge; writedata bits above the register width are ignored.
REQ-014 SHALL map address 0 to DATA (R/W, WIDTH bits).
REQ-015 SHALL map address 1 to PULSE_LEN (R/W, CNT_W bits); a value of 0 SHALL behave as 1.
REQ-016 SHALL map address 2 to PULSE_CTRL: a write of nonzero mask[WIDTH-1:0] starts a pulse; a read returns busy in bit 31 and the active mask in [WIDTH-1:0].
REQ-017 SHALL map address 3 to STATUS (REQ-033/034).
REQ-018 SHALL map address 4 to OUTSET: DATA <= DATA | writedata[WIDTH-1:0]; reads return 0.
REQ-019 SHALL map address 5 to OUTCLEAR: DATA <= DATA & ~writedata[WIDTH-1:0]; reads return 0.
REQ-020 SHALL return 0 on reads of addresses 6 and 7 and ignore writes to them; unused readdata bits read 0.
REQ-021 SHALL implement a two-state FSM, IDLE and PULSE.
REQ-022 SHALL transition IDLE->PULSE on a nonzero PULSE_CTRL write, loading mask <= writedata[WIDTH-1:0] and cnt <= max(PULSE_LEN,1).
REQ-023 SHALL decrement cnt each cycle in PULSE; at cnt==1 it SHALL transition to IDLE and clear mask.
REQ-024 SHALL drive out_port = DATA ^ mask, so each masked line inverts for exactly max(PULSE_LEN,1) cycles, starting the cycle after the trigger write.
REQ-025 SHALL ignore a PULSE_CTRL write while in PULSE, with no retrigger or extension.
REQ-026 SHALL ignore a zero-mask PULSE_CTRL write.
REQ-027 SHALL update DATA immediately on writes to DATA/OUTSET/OUTCLEAR during PULSE, with out_port reflecting new DATA ^ mask.
REQ-028 SHALL apply a PULSE_LEN write during PULSE to the next pulse only.
REQ-029 SHALL hold mask at 0 in IDLE, making out_port == DATA.

Reset
REQ-030 SHALL, on reset assertion, asynchronously set DATA=RESET_VALUE[WIDTH-1:0], PULSE_LEN=1, mask=0, cnt=0, state=IDLE, done=0.
REQ-031 SHALL hold out_port=RESET_VALUE[WIDTH-1:0] and irq=0 during reset, including reset asserted mid-pulse, which aborts the pulse with no done set.
REQ-032 SHALL ignore bus writes while reset is asserted.

Configuration
REQ-033 SHALL compile in, with macro NIOS_PIO_PULSE_IRQ_EN defined, a sticky done bit (STATUS bit 0) set on the PULSE->IDLE cycle; writing STATUS with bit 0 = 1 clears it; a set on the same cycle as a clear wins; irq = done.
REQ-034 SHALL, without NIOS_PIO_PULSE_IRQ_EN, read STATUS as 0, ignore STATUS writes, and tie irq to 0.

Verification
REQ-035 SHALL check: WIDTH=1, reset released -> out_port=1, readdata@0=1, PULSE_LEN@1=1.
REQ-036 SHALL check: PULSE_LEN=3, PULSE_CTRL=1 -> out_port low exactly 3 cycles from the cycle after the write, then 1; busy reads 1 during the pulse.
REQ-037 SHALL check: WIDTH=8, DATA=0x0F, OUTSET 0x30, OUTCLEAR 0x01 -> DATA=0x3E.
REQ-038 SHALL check: PULSE_CTRL=0x01 then retrigger 0x02 mid-pulse -> 0x02 ignored; PULSE_LEN=0 -> 1-cycle pulse.
REQ-039 SHALL check: with NIOS_PIO_PULSE_IRQ_EN, pulse end -> irq=1; STATUS write 1 -> irq=0 next cycle; reset mid-pulse -> irq stays 0.

Source files
------------

// File: rtl/nios_pio_pulse_if.sv
// Avalon-MM slave bus bundle for nios_pio_pulse (zero-wait-state reads).
interface nios_pio_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_pio_pulse.sv
// nios_pio_pulse: Avalon-MM output PIO with a timed invert-pulse engine.
//   addr 0 DATA, 1 PULSE_LEN, 2 PULSE_CTRL (busy@31, mask), 3 STATUS,
//   4 OUTSET, 5 OUTCLEAR, 6/7 reserved (read 0).
// Optional: define NIOS_PIO_PULSE_IRQ_EN for a sticky pulse-done bit and irq.
module nios_pio_pulse #(
    parameter int unsigned WIDTH       = 1,
    parameter logic [31:0] RESET_VALUE = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_pio_pulse_if.slave        bus,
    output logic [WIDTH-1:0]       out_port,
    output logic                   irq
);
    typedef enum logic {S_IDLE = 1'b0, S_PULSE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [WIDTH-1:0] r_mask, w_mask_nxt;
    logic [CNT_W-1:0] r_len, w_len_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_wr;
    logic             w_pulse_end;
    logic [WIDTH-1:0] w_wd;
    logic             w_status;
    logic [31:0]      w_rd;

    assign w_wr = bus.chipselect & ~bus.write_n;
    assign w_wd = bus.writedata[WIDTH-1:0];

    // Register-file writes: DATA / PULSE_LEN / OUTSET / OUTCLEAR take effect at
    // once, regardless of pulse state (a new length only matters at next trigger).
    always_comb begin
        w_data_nxt = r_data;
        w_len_nxt  = r_len;
        if (w_wr) begin
            case (bus.address)
                3'd0:    w_data_nxt = w_wd;
                3'd1:    w_len_nxt  = bus.writedata[CNT_W-1:0];
                3'd4:    w_data_nxt = r_data | w_wd;
                3'd5:    w_data_nxt = r_data & ~w_wd;
                default: ;
            endcase
        end
    end

    // Pulse FSM next state: trigger only from IDLE with a nonzero mask; the
    // counter holds remaining pulse cycles including the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_cnt_nxt   = r_cnt;
        w_pulse_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr && bus.address == 3'd2 && w_wd != '0) begin
                    w_state_nxt = S_PULSE;
                    w_mask_nxt  = w_wd;
                    w_cnt_nxt   = (r_len == '0) ? LEN_ONE : r_len;
                end
            end
            S_PULSE: begin
                if (r_cnt <= LEN_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_mask_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_pulse_end = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LEN_ONE;
                end
            end
        endcase
    end

    // State register; reset restores idle-level outputs and aborts any pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= RESET_VALUE[WIDTH-1:0];
            r_mask  <= '0;
            r_len   <= LEN_ONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_mask  <= w_mask_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef NIOS_PIO_PULSE_IRQ_EN
    logic r_done, w_done_nxt;

    // Sticky done: cleared by writing STATUS bit0, but a same-cycle set wins.
    always_comb begin
        w_done_nxt = r_done;
        if (w_wr && bus.address == 3'd3 && bus.writedata[0]) w_done_nxt = 1'b0;
        if (w_pulse_end) w_done_nxt = 1'b1;
    end

    // Done register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_done <= 1'b0;
        else       r_done <= w_done_nxt;
    end

    assign w_status = r_done;
    assign irq      = r_done;
`else
    assign w_status = 1'b0;
    assign irq      = 1'b0;
`endif

    // Combinational readback; busy overrides mask bit 31 when WIDTH == 32.
    always_comb begin
        w_rd = '0;
        case (bus.address)
            3'd0: w_rd[WIDTH-1:0] = r_data;
            3'd1: w_rd[CNT_W-1:0] = r_len;
            3'd2: begin
                w_rd[WIDTH-1:0] = r_mask;
                w_rd[31]        = (r_state == S_PULSE);
            end
            3'd3:    w_rd[0] = w_status;
            default: ;
        endcase
    end

    assign bus.readdata = w_rd;
    assign out_port     = r_data ^ r_mask;
endmodule

// File: tb/tb_nios_pio_pulse.sv
// Bench for nios_pio_pulse: WIDTH=1 and WIDTH=8 instances, table vectors,
// directed pulse sequences and a timestamp-based random reference model.
module tb_nios_pio_pulse;
`ifdef NIOS_PIO_PULSE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:0] out1;
    logic [7:0] out8;
    logic       irq1, irq8;
    int         total = 0;
    int         bad = 0;

    nios_pio_pulse_if bus1 ();
    nios_pio_pulse_if bus8 ();

    nios_pio_pulse #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .out_port(out1), .irq(irq1));
    nios_pio_pulse #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave), .out_port(out8), .irq(irq8));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] erd;
        logic [7:0]  eout;
    } vec_t;
    vec_t tbl[9];

    // reference model for the WIDTH=8 instance: pulse described by its end time
    logic [7:0]  m_data, m_mask;
    logic [15:0] m_len;
    int          m_cyc, m_end;
    bit          m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input bit s8, input logic [2:0] a, input logic [31:0] d);
        if (s8) begin
            bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = d; bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        end
        step();
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
        bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
    endtask

    task automatic rd(input bit s8, input logic [2:0] a, output logic [31:0] v);
        if (s8) begin bus8.address = a; #1; v = bus8.readdata; end
        else    begin bus1.address = a; #1; v = bus1.readdata; end
    endtask

    function automatic bit m_busy();
        return m_cyc < m_end;
    endfunction

    function automatic logic [7:0] m_out();
        return m_data ^ (m_busy() ? m_mask : 8'h00);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_data};
            3'd1: return {16'h0, m_len};
            3'd2: return m_busy() ? {1'b1, 23'h0, m_mask} : 32'h0;
            3'd3: return {31'h0, IRQ_EN & m_done};
            default: return 32'h0;
        endcase
    endfunction

    task automatic rstep(input bit w, input logic [2:0] a, input logic [31:0] d);
        int          j;
        int          plen;
        bit          busy_b;
        logic [2:0]  ra;
        logic [31:0] v;
        if (w) begin
            bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
        end
        step();
        bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
        j      = m_cyc + 1;
        busy_b = m_busy();
        if (w) begin
            case (a)
                3'd0: m_data = d[7:0];
                3'd1: m_len  = d[15:0];
                3'd2: if (!busy_b && d[7:0] != 8'h0) begin
                    plen   = (m_len == 16'h0) ? 1 : int'(m_len);
                    m_mask = d[7:0];
                    m_end  = j + plen;
                end
                3'd3: if (d[0]) m_done = 1'b0;
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                default: ;
            endcase
        end
        if (busy_b && j >= m_end) m_done = 1'b1;
        m_cyc = j;
        chk("rnd_out", {24'h0, out8}, {24'h0, m_out()});
        chk("rnd_irq", {31'h0, irq8}, {31'h0, IRQ_EN & m_done});
        ra = 3'($urandom_range(0, 7));
        rd(1'b1, ra, v);
        chk("rnd_rd", v, m_read(ra));
    endtask

    initial begin
        logic [31:0] v;
        logic [2:0]  a;
        logic [31:0] d;
        bit          w;

        tbl[0] = '{3'd0, 32'h0000_000F, 3'd0, 32'h0000_000F, 8'h0F};
        tbl[1] = '{3'd4, 32'h0000_0030, 3'd0, 32'h0000_003F, 8'h3F};
        tbl[2] = '{3'd5, 32'h0000_0001, 3'd0, 32'h0000_003E, 8'h3E};
        tbl[3] = '{3'd0, 32'h0000_0123, 3'd0, 32'h0000_0023, 8'h23};
        tbl[4] = '{3'd1, 32'h0005_0007, 3'd1, 32'h0000_0007, 8'h23};
        tbl[5] = '{3'd6, 32'h0000_FFFF, 3'd6, 32'h0000_0000, 8'h23};
        tbl[6] = '{3'd7, 32'h0000_0005, 3'd4, 32'h0000_0000, 8'h23};
        tbl[7] = '{3'd3, 32'h0000_0001, 3'd5, 32'h0000_0000, 8'h23};
        tbl[8] = '{3'd2, 32'h0000_0F00, 3'd2, 32'h0000_0000, 8'h23};

        bus1.address = 3'd0; bus1.writedata = 32'h0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
        bus8.address = 3'd0; bus8.writedata = 32'h0; bus8.chipselect = 1'b0; bus8.write_n = 1'b1;

        // reset state
        repeat (2) step();
        chk("rst_out1", {31'h0, out1}, 32'h1);
        chk("rst_out8", {24'h0, out8}, 32'hFF);
        chk("rst_irq1", {31'h0, irq1}, 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_out1", {31'h0, out1}, 32'h1);
        rd(1'b0, 3'd0, v); chk("post_rst_data1", v, 32'h1);
        rd(1'b0, 3'd1, v); chk("post_rst_len1", v, 32'h1);
        rd(1'b0, 3'd2, v); chk("post_rst_ctrl1", v, 32'h0);
        rd(1'b0, 3'd3, v); chk("post_rst_status1", v, 32'h0);

        // register table on the 8-bit instance
        for (int i = 0; i < 9; i++) begin
            wr(1'b1, tbl[i].wa, tbl[i].wd);
            rd(1'b1, tbl[i].ra, v);
            chk($sformatf("tbl%0d_rd", i), v, tbl[i].erd);
            chk($sformatf("tbl%0d_out", i), {24'h0, out8}, {24'h0, tbl[i].eout});
        end

        // 3-cycle low strobe on WIDTH=1
        wr(1'b0, 3'd1, 32'd3);
        wr(1'b0, 3'd2, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("len3_low%0d", i), {31'h0, out1}, 32'h0);
            rd(1'b0, 3'd2, v); chk($sformatf("len3_busy%0d", i), v, 32'h8000_0001);
            step();
        end
        chk("len3_high", {31'h0, out1}, 32'h1);
        rd(1'b0, 3'd2, v); chk("len3_idle", v, 32'h0);
        chk("done_irq", {31'h0, irq1}, {31'h0, IRQ_EN});
        rd(1'b0, 3'd3, v); chk("done_status", v, {31'h0, IRQ_EN});
        wr(1'b0, 3'd3, 32'h0);
        chk("clr0_keeps_irq", {31'h0, irq1}, {31'h0, IRQ_EN});
        wr(1'b0, 3'd3, 32'h1);
        chk("clr1_irq", {31'h0, irq1}, 32'h0);
        // set on the same edge as a clear: set wins
        wr(1'b0, 3'd1, 32'd1);
        wr(1'b0, 3'd2, 32'd1);
        chk("len1_low", {31'h0, out1}, 32'h0);
        wr(1'b0, 3'd3, 32'h1);
        chk("setwins_out", {31'h0, out1}, 32'h1);
        chk("setwins_irq", {31'h0, irq1}, {31'h0, IRQ_EN});
        wr(1'b0, 3'd3, 32'h1);
        chk("setwins_clr", {31'h0, irq1}, 32'h0);

        // retrigger ignored, DATA write mid-pulse, zero length, deferred length
        wr(1'b1, 3'd0, 32'h0);
        wr(1'b1, 3'd1, 32'd4);
        wr(1'b1, 3'd2, 32'h01);
        chk("rt_start", {24'h0, out8}, 32'h01);
        step();
        wr(1'b1, 3'd2, 32'h02);
        chk("rt_ignored", {24'h0, out8}, 32'h01);
        rd(1'b1, 3'd2, v); chk("rt_ctrl", v, 32'h8000_0001);
        wr(1'b1, 3'd0, 32'h10);
        chk("mid_data", {24'h0, out8}, 32'h11);
        step();
        chk("rt_end", {24'h0, out8}, 32'h10);
        wr(1'b1, 3'd1, 32'd0);
        wr(1'b1, 3'd2, 32'h80);
        chk("len0_on", {24'h0, out8}, 32'h90);
        step();
        chk("len0_off", {24'h0, out8}, 32'h10);
        wr(1'b1, 3'd1, 32'd2);
        wr(1'b1, 3'd2, 32'h01);
        chk("defer_on", {24'h0, out8}, 32'h11);
        wr(1'b1, 3'd1, 32'd5);
        chk("defer_mid", {24'h0, out8}, 32'h11);
        step();
        chk("defer_end", {24'h0, out8}, 32'h10);
        wr(1'b1, 3'd2, 32'h01);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("len5_on%0d", i), {24'h0, out8}, 32'h11);
            step();
        end
        chk("len5_off", {24'h0, out8}, 32'h10);

        // reset mid-pulse aborts without done; writes during reset ignored
        wr(1'b0, 3'd1, 32'd10);
        wr(1'b0, 3'd2, 32'd1);
        step();
        chk("abort_low", {31'h0, out1}, 32'h0);
        reset = 1'b1;
        #1;
        chk("abort_out1", {31'h0, out1}, 32'h1);
        chk("abort_irq1", {31'h0, irq1}, 32'h0);
        chk("abort_out8", {24'h0, out8}, 32'hFF);
        wr(1'b1, 3'd0, 32'h0);
        rd(1'b1, 3'd0, v); chk("rst_wr_ignored", v, 32'hFF);
        reset = 1'b0;
        repeat (3) step();
        chk("abort_irq_after", {31'h0, irq1}, 32'h0);
        chk("abort_out1_after", {31'h0, out1}, 32'h1);
        rd(1'b0, 3'd2, v); chk("abort_ctrl", v, 32'h0);

        // randomized traffic against the reference model
        m_data = 8'hFF; m_mask = 8'h0; m_len = 16'h1; m_cyc = 0; m_end = 0; m_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            w = ($urandom_range(0, 2) != 0);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd1) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            if (a == 3'd2 && $urandom_range(0, 3) == 0) d = d & 32'hFFFF_FF00;
            rstep(w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
